// File: rtl/subservient_wb_loader.sv
// Wishbone classic slave that streams firmware words byte-by-byte into the
// subservient SRAM write port while holding the SERV core in reset.
module subservient_wb_loader #(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int unsigned AW       = 10
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic [AW-1:0] sram_waddr,
   output logic [7:0]    sram_wdata,
   output logic          sram_wen,
   output logic          core_rst_o
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      ACK
   } state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_ADDR   = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   state_e        state_q, state_d;
   logic [1:0]    lane_q, lane_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          core_rst_q, core_rst_d;
   logic          err_q, err_d;
   logic          abort_q, abort_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;

   logic          req;
   logic          hit;
   logic [1:0]    reg_sel;
   logic [31:0]   sel_mask;
   logic [AW-1:0] addr_wr;
   logic [31:0]   rdata;
   logic          unused_adr;

   assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign hit        = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign reg_sel    = wbs_adr_i[3:2];
   assign unused_adr = ^wbs_adr_i[1:0];

   assign sel_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign addr_wr  = (addr_q & ~sel_mask[AW-1:0]) | (wbs_dat_i[AW-1:0] & sel_mask[AW-1:0]);

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL:   rdata = {31'd0, core_rst_q};
         REG_ADDR:   rdata = 32'(addr_q);
         REG_DATA:   rdata = last_q;
         REG_STATUS: rdata = {30'd0, err_q, 1'b0};
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      lane_d     = lane_q;
      sel_d      = sel_q;
      last_d     = last_q;
      addr_d     = addr_q;
      core_rst_d = core_rst_q;
      err_d      = err_q;
      abort_d    = abort_q;
      ack_d      = 1'b0;
      dat_d      = '0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit && wbs_we_i && reg_sel == REG_DATA && core_rst_q) begin
                  last_d  = wbs_dat_i;
                  sel_d   = wbs_sel_i;
                  lane_d  = 2'd0;
                  abort_d = 1'b0;
                  state_d = STREAM;
               end else begin
                  ack_d = 1'b1;
                  if (hit && wbs_we_i) begin
                     case (reg_sel)
                        REG_CTRL:   if (wbs_sel_i[0]) core_rst_d = wbs_dat_i[0];
                        REG_ADDR:   addr_d = addr_wr;
                        REG_DATA:   err_d = 1'b1;  // core running: loading refused
                        REG_STATUS: if (wbs_sel_i[0] && wbs_dat_i[1]) err_d = 1'b0;
                        default:    ;
                     endcase
                  end else if (hit) begin
                     dat_d = rdata;
                  end
               end
            end
         end
         STREAM: begin
            if (!wbs_cyc_i) abort_d = 1'b1;
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
               addr_d = addr_q + AW'(4);
               if (abort_d) begin
                  state_d = IDLE;
               end else begin
                  ack_d   = 1'b1;
                  state_d = ACK;
               end
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         lane_q     <= 2'd0;
         sel_q      <= 4'd0;
         last_q     <= '0;
         addr_q     <= '0;
         core_rst_q <= 1'b1;
         err_q      <= 1'b0;
         abort_q    <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         core_rst_q <= core_rst_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
      end
   end

   // SRAM port is decoded from state so an async reset drops sram_wen at once.
   always_comb begin
      sram_wen   = 1'b0;
      sram_waddr = '0;
      sram_wdata = '0;
      if (state_q == STREAM) begin
         sram_wen   = sel_q[lane_q];
         sram_waddr = addr_q + AW'(lane_q);
         sram_wdata = last_q[{lane_q, 3'b000} +: 8];
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_subservient_wb_loader.sv
// Directed bench for subservient_wb_loader: register access, byte streaming,
// address wrap, error flag, aborted cycles, async reset and unmapped decode.
module tb_subservient_wb_loader;

   localparam int unsigned AW   = 10;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc, stb, we;
   logic [3:0]    sel;
   logic [31:0]   adr, dat_w;
   logic          ack;
   logic [31:0]   dat_r;
   logic [AW-1:0] sram_waddr;
   logic [7:0]    sram_wdata;
   logic          sram_wen;
   logic          core_rst;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
      int            c;
   } wr_t;
   wr_t wr_q[$];

   subservient_wb_loader #(.BASE_ADR(BASE), .AW(AW)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_r),
      .sram_waddr(sram_waddr),
      .sram_wdata(sram_wdata),
      .sram_wen  (sram_wen),
      .core_rst_o(core_rst)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (sram_wen === 1'b1) wr_q.push_back('{a: sram_waddr, d: sram_wdata, c: cyc_cnt});
   end

   // One Wishbone access; lat counts clock edges from request until ack is seen.
   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (ack !== 1'b1 && lat < 40);
      rd = dat_r;
      if (ack !== 1'b1) begin
         checks++; errors++;
         $display("FAIL bus_timeout: adr=%h no ack after %0d cycles", a, lat);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int lat;
      rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
      #1;
      checks++;
      if ({core_rst, ack, sram_wen} !== 3'b100 || dat_r !== 32'd0 || sram_waddr !== '0 || sram_wdata !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: core_rst=%b ack=%b wen=%b dat=%h waddr=%h wdata=%h want 1 0 0 0 0 0",
                  core_rst, ack, sram_wen, dat_r, sram_waddr, sram_wdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus(0, BASE + 32'h0, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h1 || lat !== 1) begin
         errors++; $display("FAIL reset_ctrl: got %h lat %0d want 00000001 lat 1", rd, lat);
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", rd); end
      bus(0, BASE + 32'hC, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", rd); end
      checks++;
      if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
   endtask

   task automatic test_stream_full();
      logic [31:0]   rd;
      int            lat;
      logic [AW-1:0] ea[4] = '{10'h010, 10'h011, 10'h012, 10'h013};
      logic [7:0]    ed[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      bus(1, BASE + 32'h4, 32'h010, 4'hF, rd, lat);
      wr_q.delete();
      bus(1, BASE + 32'h8, 32'hDDCCBBAA, 4'hF, rd, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL full_latency: got %0d want 5", lat); end
      checks++;
      if (wr_q.size() !== 4) begin
         errors++; $display("FAIL full_count: got %0d writes want 4", wr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_q[i].a !== ea[i] || wr_q[i].d !== ed[i] || (i > 0 && wr_q[i].c !== wr_q[i-1].c + 1)) begin
               errors++;
               $display("FAIL full_byte%0d: got %h=%h cyc %0d want %h=%h consecutive",
                        i, wr_q[i].a, wr_q[i].d, wr_q[i].c, ea[i], ed[i]);
            end
         end
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h014) begin errors++; $display("FAIL full_addr: got %h want 00000014", rd); end
      bus(0, BASE + 32'h8, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL full_last: got %h want ddccbbaa", rd); end
   endtask

   task automatic test_stream_sparse();
      logic [31:0] rd;
      int          lat;
      bus(1, BASE + 32'h4, 32'h020, 4'hF, rd, lat);
      wr_q.delete();
      bus(1, BASE + 32'h8, 32'h44332211, 4'h5, rd, lat);
      checks++;
      if (wr_q.size() !== 2) begin
         errors++; $display("FAIL sparse_count: got %0d writes want 2", wr_q.size());
      end else begin
         checks++;
         if (wr_q[0].a !== 10'h020 || wr_q[0].d !== 8'h11 || wr_q[1].a !== 10'h022 || wr_q[1].d !== 8'h33) begin
            errors++;
            $display("FAIL sparse_bytes: got %h=%h %h=%h want 020=11 022=33",
                     wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d);
         end
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h024) begin errors++; $display("FAIL sparse_addr: got %h want 00000024", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0]   rd;
      int            lat;
      logic [AW-1:0] ea[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      logic [7:0]    ed[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      bus(1, BASE + 32'h4, 32'h3FE, 4'hF, rd, lat);
      wr_q.delete();
      bus(1, BASE + 32'h8, 32'h04030201, 4'hF, rd, lat);
      checks++;
      if (wr_q.size() !== 4) begin
         errors++; $display("FAIL wrap_count: got %0d writes want 4", wr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_q[i].a !== ea[i] || wr_q[i].d !== ed[i]) begin
               errors++;
               $display("FAIL wrap_byte%0d: got %h=%h want %h=%h", i, wr_q[i].a, wr_q[i].d, ea[i], ed[i]);
            end
         end
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h002) begin errors++; $display("FAIL wrap_addr: got %h want 00000002", rd); end
   endtask

   task automatic test_err();
      logic [31:0] rd;
      int          lat;
      bus(1, BASE + 32'h0, 32'h0, 4'hF, rd, lat);
      checks++;
      if (core_rst !== 1'b0) begin errors++; $display("FAIL err_core_release: got %b want 0", core_rst); end
      wr_q.delete();
      bus(1, BASE + 32'h8, 32'h12345678, 4'hF, rd, lat);
      checks++;
      if (lat !== 1 || wr_q.size() !== 0) begin
         errors++; $display("FAIL err_data_refused: lat %0d writes %0d want lat 1 writes 0", lat, wr_q.size());
      end
      bus(0, BASE + 32'hC, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h2) begin errors++; $display("FAIL err_status_set: got %h want 00000002", rd); end
      bus(1, BASE + 32'hC, 32'h2, 4'hF, rd, lat);
      bus(0, BASE + 32'hC, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL err_status_clear: got %h want 00000000", rd); end
      checks++;
      if (core_rst !== 1'b0) begin errors++; $display("FAIL err_core_held: got %b want 0", core_rst); end
   endtask

   task automatic test_cyc_drop();
      logic [31:0] rd;
      int          lat;
      int          acks = 0;
      bus(1, BASE + 32'h0, 32'h1, 4'h1, rd, lat);
      checks++;
      if (core_rst !== 1'b1) begin errors++; $display("FAIL drop_core_reassert: got %b want 1", core_rst); end
      bus(1, BASE + 32'h4, 32'h100, 4'hF, rd, lat);
      wr_q.delete();
      cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; dat_w = 32'hA3A2A1A0; sel = 4'hF;
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack === 1'b1) acks++;
      end
      checks++;
      if (acks !== 0 || wr_q.size() !== 4) begin
         errors++; $display("FAIL drop_stream: acks %0d writes %0d want acks 0 writes 4", acks, wr_q.size());
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h104) begin errors++; $display("FAIL drop_addr: got %h want 00000104", rd); end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      int          lat;
      int          acks = 0;
      bus(1, BASE + 32'h4, 32'h040, 4'hF, rd, lat);
      wr_q.delete();
      cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; dat_w = 32'h87654321; sel = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (sram_wen !== 1'b1 || sram_waddr !== 10'h041) begin
         errors++; $display("FAIL arst_pre: wen %b waddr %h want 1 041", sram_wen, sram_waddr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (sram_wen !== 1'b0 || core_rst !== 1'b1 || ack !== 1'b0) begin
         errors++; $display("FAIL arst_immediate: wen %b core_rst %b ack %b want 0 1 0", sram_wen, core_rst, ack);
      end
      cyc = 0; stb = 0; we = 0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack === 1'b1) acks++;
      end
      checks++;
      if (acks !== 0 || wr_q.size() !== 1) begin
         errors++; $display("FAIL arst_no_retry: acks %0d writes %0d want acks 0 writes 1", acks, wr_q.size());
      end
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0 || core_rst !== 1'b1) begin
         errors++; $display("FAIL arst_state: addr %h core_rst %b want 00000000 1", rd, core_rst);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      int          lat;
      bus(0, 32'h3000_0108, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0 || lat !== 1) begin
         errors++; $display("FAIL unmapped_read: got %h lat %0d want 00000000 lat 1", rd, lat);
      end
      bus(1, 32'h3000_0104, 32'h55, 4'hF, rd, lat);
      bus(0, BASE + 32'h4, 0, 4'hF, rd, lat);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_write: ADDR got %h want 00000000", rd); end
   endtask

   initial begin
      test_reset();
      test_stream_full();
      test_stream_sparse();
      test_wrap();
      test_err();
      test_cyc_drop();
      test_async_reset();
      test_unmapped();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
